// File: rtl/zoned_anti_theft_ctrl_pkg.sv
// anti_theft_pkg: shared state encoding, counter width and entry-delay selection for the zoned alarm
package anti_theft_pkg;
  localparam int AC_W = 3;
  typedef enum logic [2:0] {
    ARMED, TRIGGERED, ALARM, DISARMED, WAIT_OPEN, WAIT_CLOSE, WAIT_TIME, LOCKOUT
  } state_t;
  // Driver door alone earns the shorter entry delay
  function automatic int entry_delay(input logic [7:0] z, input int t_driver, input int t_pass);
    return (z == 8'd1) ? t_driver : t_pass;
  endfunction
endpackage

// File: rtl/zoned_anti_theft_ctrl_if.sv
// zoned_anti_theft_ctrl_if: sensor/tick inputs and siren/status outputs of the alarm controller
interface zoned_anti_theft_ctrl_if #(parameter int N_ZONES = 4);
  import anti_theft_pkg::*;
  logic tick;
  logic ignition;
  logic reprogram;
  logic [N_ZONES-1:0] zone;
  logic status;
  logic siren;
  logic lockout;
  logic [N_ZONES-1:0] zone_latched;
  logic [AC_W-1:0] alarm_count;
  modport master (output tick, ignition, reprogram, zone,
                  input status, siren, lockout, zone_latched, alarm_count);
  modport slave (input tick, ignition, reprogram, zone,
                 output status, siren, lockout, zone_latched, alarm_count);
endinterface

// File: rtl/zoned_anti_theft_ctrl_tick_timer.sv
// tick_timer: loadable down counter decremented on tick, expired when it reaches zero
module tick_timer #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= load_val;
    else if (tick && count != '0) count <= count - 1'b1;
  assign expired = count == '0;
endmodule

// File: rtl/zoned_anti_theft_ctrl.sv
// zoned_anti_theft_ctrl: N-zone vehicle alarm FSM with entry delay, siren bursts, lockout and re-arm sequencing
module zoned_anti_theft_ctrl
  import anti_theft_pkg::*;
#(
  parameter int N_ZONES    = 4,
  parameter int T_DRIVER   = 8,
  parameter int T_PASS     = 15,
  parameter int T_ALARM    = 10,
  parameter int T_ARM      = 6,
  parameter int BLINK_DIV  = 2,
  parameter int MAX_ALARMS = 3
) (
  input logic clk,
  input logic rst_n,
  zoned_anti_theft_ctrl_if.slave bus
);
  localparam int T_MAX_A = T_DRIVER > T_PASS ? T_DRIVER : T_PASS;
  localparam int T_MAX_B = T_ALARM > T_ARM ? T_ALARM : T_ARM;
  localparam int T_MAX = T_MAX_A > T_MAX_B ? T_MAX_A : T_MAX_B;
  localparam int W = $clog2(T_MAX + 1);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [AC_W-1:0] AC_MAX = AC_W'(MAX_ALARMS);

  if (!(T_DRIVER >= 1 && T_PASS >= 1 && T_ALARM >= 1 && T_ARM >= 1 && BLINK_DIV >= 1 &&
        N_ZONES >= 2 && N_ZONES <= 8 && MAX_ALARMS >= 1 && MAX_ALARMS <= 7)) begin : g_param_check
    $error("zoned_anti_theft_ctrl: illegal parameter value");
  end

  state_t state, nxt;
  logic [N_ZONES-1:0] zl, zl_nxt;
  logic [AC_W-1:0] ac, ac_nxt, ac_inc;
  logic [BW-1:0] blink, blink_nxt;
  logic [W-1:0] load_val;
  logic z0_q, rise, fall, reload, load, expired;
  logic status_q, siren_q, lockout_q;

  assign ac_inc = ac == '1 ? ac : ac + 1'b1;
  assign rise = bus.zone[0] & ~z0_q;
  assign fall = ~bus.zone[0] & z0_q;

  always_comb begin
    nxt = state;
    zl_nxt = zl;
    ac_nxt = ac;
    reload = 1'b0;
    case (state)
      ARMED:
        if (|bus.zone) begin
          nxt = TRIGGERED;
          zl_nxt = zl | bus.zone;
        end else if (bus.ignition) nxt = DISARMED;
      TRIGGERED:
        if (bus.ignition) nxt = DISARMED;
        else begin
          zl_nxt = zl | bus.zone;
          if (expired) begin
            nxt = ALARM;
            ac_nxt = ac_inc;
          end
        end
      ALARM:
        if (bus.ignition) nxt = DISARMED;
        else if (expired) begin
          if (ac >= AC_MAX) nxt = LOCKOUT;
          else if (|bus.zone) begin
            reload = 1'b1;
            ac_nxt = ac_inc;
          end else nxt = ARMED;
        end
      LOCKOUT:    nxt = bus.ignition ? DISARMED : LOCKOUT;
      DISARMED:   nxt = bus.ignition ? DISARMED : WAIT_OPEN;
      WAIT_OPEN:  nxt = bus.ignition ? DISARMED : rise ? WAIT_CLOSE : WAIT_OPEN;
      WAIT_CLOSE: nxt = bus.ignition ? DISARMED : fall ? WAIT_TIME : WAIT_CLOSE;
      WAIT_TIME:  nxt = bus.ignition ? DISARMED : rise ? WAIT_CLOSE : expired ? ARMED : WAIT_TIME;
      default:    nxt = ARMED;
    endcase
    if (nxt == DISARMED) begin
      zl_nxt = '0;
      ac_nxt = '0;
    end
    if (bus.reprogram) begin
      nxt = ARMED;
      zl_nxt = '0;
      ac_nxt = '0;
      reload = 1'b0;
    end
  end

  // Every state entry (and an ALARM retrigger) reloads the timer; untimed states load zero
  always_comb begin
    load = bus.reprogram | reload | (nxt != state);
    load_val = nxt == TRIGGERED ? W'(entry_delay(8'(bus.zone), T_DRIVER, T_PASS)) :
               nxt == ALARM     ? W'(T_ALARM) :
               nxt == WAIT_TIME ? W'(T_ARM) : '0;
    blink_nxt = (nxt == ARMED && (state != ARMED || bus.reprogram)) ? '0 :
                (state == ARMED && bus.tick) ? (blink == BLINK_LAST ? '0 : blink + 1'b1) : blink;
  end

  tick_timer #(.W(W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (bus.tick),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARMED;
      zl <= '0;
      ac <= '0;
      blink <= '0;
      z0_q <= 1'b0;
      status_q <= 1'b0;
      siren_q <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state <= nxt;
      zl <= zl_nxt;
      ac <= ac_nxt;
      blink <= blink_nxt;
      z0_q <= bus.zone[0];
      status_q <= nxt == ARMED ? blink_nxt == BLINK_LAST : nxt inside {TRIGGERED, ALARM, LOCKOUT};
      siren_q <= nxt == ALARM;
      lockout_q <= nxt == LOCKOUT;
    end

  assign bus.status = status_q;
  assign bus.siren = siren_q;
  assign bus.lockout = lockout_q;
  assign bus.zone_latched = zl;
  assign bus.alarm_count = ac;
endmodule
